// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter: shares the SDRAM Avalon read port between audio fetch (A, priority) and a secondary reader (B)
module mem_read_arbiter #(
    parameter int ADDR_W         = 25,
    parameter int DATA_W         = 16,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk50,
    input  logic              reset_n,
    input  logic              arb_enable,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_gnt,
    output logic              a_valid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    output logic              b_gnt,
    output logic              b_valid,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] ADDR_PRGM,
    output logic              RDen,
    input  logic [DATA_W-1:0] RDdata_PRGM,
    input  logic              avalon_bridge_acknowledge,
    output logic              timeout_err,
    input  logic              err_clr
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ISSUE  = 2'd1;
    localparam logic [1:0] RETURN = 2'd2;

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    state;
    logic [SW-1:0] starve_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          win_b;
    logic          grant;
    logic          pick_b;
    logic          ack_hit;
    logic          tmo_hit;

    // Arbitration decision and ISSUE-state completion conditions
    always_comb begin
        grant   = (state == IDLE) && arb_enable && (a_req || b_req);
        pick_b  = b_req && (!a_req || (starve_cnt == SW'(STARVE_LIMIT)));
        ack_hit = (state == ISSUE) && avalon_bridge_acknowledge;
        tmo_hit = (state == ISSUE) && !avalon_bridge_acknowledge && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    end

    // Access sequencer: IDLE grants, ISSUE holds RDen until ack or timeout, RETURN forces an RDen-low gap
    always_ff @(posedge clk50) begin
        if (!reset_n) begin
            state     <= IDLE;
            RDen      <= 1'b0;
            ADDR_PRGM <= '0;
            win_b     <= 1'b0;
            tmo_cnt   <= '0;
            a_gnt     <= 1'b0;
            b_gnt     <= 1'b0;
            a_valid   <= 1'b0;
            b_valid   <= 1'b0;
            a_rdata   <= '0;
            b_rdata   <= '0;
        end else begin
            a_gnt   <= 1'b0;
            b_gnt   <= 1'b0;
            a_valid <= 1'b0;
            b_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        ADDR_PRGM <= pick_b ? b_addr : a_addr;
                        RDen      <= 1'b1;
                        a_gnt     <= !pick_b;
                        b_gnt     <= pick_b;
                        win_b     <= pick_b;
                        tmo_cnt   <= '0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (ack_hit || tmo_hit) begin
                        RDen    <= 1'b0;
                        a_valid <= !win_b;
                        b_valid <= win_b;
                        state   <= RETURN;
                        if (win_b) b_rdata <= ack_hit ? RDdata_PRGM : '0;
                        else       a_rdata <= ack_hit ? RDdata_PRGM : '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                default: begin
                    RDen  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Starvation guard: count A wins while B waits, reset when B is served or stops asking
    always_ff @(posedge clk50) begin
        if (!reset_n)
            starve_cnt <= '0;
        else if (grant && pick_b)
            starve_cnt <= '0;
        else if (grant && b_req)
            starve_cnt <= (starve_cnt == SW'(STARVE_LIMIT)) ? starve_cnt : starve_cnt + SW'(1);
        else if ((state == IDLE) && !b_req)
            starve_cnt <= '0;
    end

    // Sticky timeout flag; a new abort wins over a simultaneous clear
    always_ff @(posedge clk50) begin
        if (!reset_n)
            timeout_err <= 1'b0;
        else if (tmo_hit)
            timeout_err <= 1'b1;
        else if (err_clr)
            timeout_err <= 1'b0;
    end

endmodule
